// File: rtl/fft_stage_buffer_if.sv
// fft_stage_buffer_if
//   Handshake bundle between an FFT butterfly stage, the stage buffer and the
//   next stage.
//   in_valid  : producer presents LANES samples on in_data
//   in_ready  : buffer can take one beat of LANES samples
//   in_data   : LANES*WIDTH bits, lane k = bits [k*WIDTH +: WIDTH]
//   out_valid : out_data holds a valid sample
//   out_ready : consumer takes out_data
//   out_data  : WIDTH-bit sample
//   Modports: master = environment side (producer + consumer),
//             slave  = the buffer itself.
interface fft_stage_buffer_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 2
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/fft_stage_buffer.sv
// fft_stage_buffer
//   Sample buffer between two FFT butterfly stages. Takes LANES samples per
//   accepted beat and releases one sample per completed read.
//   FRAME_MODE = 0 : continuous ring, output valid whenever data is stored.
//   FRAME_MODE = 1 : fill DEPTH samples, then drain all of them, then refill;
//                    frame_done pulses for one cycle after the last read.
//   Ports
//     clk        : rising-edge clock
//     rst        : synchronous active-high reset (priority over flush)
//     flush      : synchronous clear of pointers, count and FSM
//     bus        : slave side of fft_stage_buffer_if (in/out handshakes)
//     count      : stored-sample occupancy, 0..DEPTH
//     full       : count == DEPTH
//     empty      : count == 0
//     frame_done : end-of-drain pulse (always 0 in STREAM mode)
module fft_stage_buffer #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int LANES      = 2,
    parameter int FRAME_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    fft_stage_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [AW-1:0] STEP_C  = AW'(LANES);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Sample storage: never reset, only pointers and occupancy are.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    state_t        state;
    state_t        state_nxt;
    logic          frame_done_q;
    logic          frame_done_nxt;

    logic          space_ok;
    logic          in_ready_c;
    logic          out_valid_c;
    logic          clear;
    logic          wr_en;
    logic          rd_en;

    // ------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------

    // Space is judged on the registered count only, so a read in the same
    // cycle never opens room early and out_ready has no path to in_ready.
    assign space_ok = (DEPTH_C - count_q) >= LANES_C;

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        if (FRAME_MODE != 0) begin
            in_ready_c  = !rst && space_ok && (state == FILL);
            out_valid_c = (state == DRAIN) && (count_q != '0);
        end else begin
            in_ready_c  = !rst && space_ok;
            out_valid_c = (count_q != '0);
        end
    end

    // A reset or flush cycle swallows any handshake presented with it.
    assign clear = rst || flush;
    assign wr_en = bus.in_valid && in_ready_c && !clear;
    assign rd_en = out_valid_c && bus.out_ready && !clear;

    // Occupancy after this cycle's traffic; a write and a read together
    // are legal and net out to LANES-1.
    always_comb begin
        count_nxt = count_q;
        if (wr_en) begin
            count_nxt = count_nxt + LANES_C;
        end
        if (rd_en) begin
            count_nxt = count_nxt - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Storage write: lane 0 lands at the lowest address of the beat
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                mem[wr_ptr + AW'(k)] <= bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + STEP_C;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state and end-of-frame pulse
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        if (FRAME_MODE != 0) begin
            case (state)
                FILL: begin
                    // Only writes happen in FILL, so reaching DEPTH here
                    // means the beat just accepted completed the frame.
                    if (wr_en && (count_nxt == DEPTH_C)) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_en && (count_nxt == '0)) begin
                        state_nxt      = FILL;
                        frame_done_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = FILL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= FILL;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_done_q <= frame_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // First-word fall-through: the head sample is always on out_data; a
    // write only becomes visible after its edge, never in the same cycle.
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_valid = out_valid_c;
    assign bus.in_ready  = in_ready_c;

    assign count      = count_q;
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign frame_done = (FRAME_MODE != 0) && frame_done_q;

endmodule

// File: tb/tb_fft_stage_buffer.sv
`timescale 1ns/1ps
module tb_fft_stage_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int LANES = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int DW    = LANES * WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // index 0 = STREAM instance, index 1 = FRAME instance
    logic            flush_d    [2];
    logic            in_valid_d [2];
    logic [DW-1:0]   in_data_d  [2];
    logic            out_ready_d[2];

    logic            in_ready_m [2];
    logic            out_valid_m[2];
    logic [WIDTH-1:0] out_data_m[2];
    logic [CW-1:0]   count_m    [2];
    logic            full_m     [2];
    logic            empty_m    [2];
    logic            fd_m       [2];

    logic [CW-1:0] cnt_s, cnt_f;
    logic full_s, full_f, empty_s, empty_f, fd_s, fd_f;

    fft_stage_buffer_if #(.WIDTH(WIDTH), .LANES(LANES)) if_s ();
    fft_stage_buffer_if #(.WIDTH(WIDTH), .LANES(LANES)) if_f ();

    fft_stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .FRAME_MODE(0)) u_stream (
        .clk(clk), .rst(rst), .flush(flush_d[0]), .bus(if_s),
        .count(cnt_s), .full(full_s), .empty(empty_s), .frame_done(fd_s)
    );
    fft_stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .FRAME_MODE(1)) u_frame (
        .clk(clk), .rst(rst), .flush(flush_d[1]), .bus(if_f),
        .count(cnt_f), .full(full_f), .empty(empty_f), .frame_done(fd_f)
    );

    assign if_s.in_valid  = in_valid_d[0];
    assign if_s.in_data   = in_data_d[0];
    assign if_s.out_ready = out_ready_d[0];
    assign if_f.in_valid  = in_valid_d[1];
    assign if_f.in_data   = in_data_d[1];
    assign if_f.out_ready = out_ready_d[1];

    assign in_ready_m[0]  = if_s.in_ready;
    assign in_ready_m[1]  = if_f.in_ready;
    assign out_valid_m[0] = if_s.out_valid;
    assign out_valid_m[1] = if_f.out_valid;
    assign out_data_m[0]  = if_s.out_data;
    assign out_data_m[1]  = if_f.out_data;
    assign count_m[0]     = cnt_s;
    assign count_m[1]     = cnt_f;
    assign full_m[0]      = full_s;
    assign full_m[1]      = full_f;
    assign empty_m[0]     = empty_s;
    assign empty_m[1]     = empty_f;
    assign fd_m[0]        = fd_s;
    assign fd_m[1]        = fd_f;

    // Reference model: stored samples as queues, plus occupancy and frame phase.
    logic [WIDTH-1:0] sbq0[$];
    logic [WIDTH-1:0] sbq1[$];
    int  mdl_cnt  [2];
    bit  mdl_drain[2];
    bit  mdl_fd   [2];
    int  dut_fd_pulses[2];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  seq;

    task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
        end
    endtask

    task automatic expect_flags(input int m, output bit exp_ir, output bit exp_ov);
        exp_ir = !rst && ((DEPTH - mdl_cnt[m]) >= LANES) && !(m == 1 && mdl_drain[m]);
        exp_ov = (mdl_cnt[m] != 0) && (m == 0 || mdl_drain[m]);
    endtask

    task automatic status(input int m);
        bit exp_ir, exp_ov;
        expect_flags(m, exp_ir, exp_ov);
        chk("count",      m, 64'(count_m[m]),    64'(mdl_cnt[m]));
        chk("full",       m, 64'(full_m[m]),     64'(mdl_cnt[m] == DEPTH));
        chk("empty",      m, 64'(empty_m[m]),    64'(mdl_cnt[m] == 0));
        chk("in_ready",   m, 64'(in_ready_m[m]), 64'(exp_ir));
        chk("out_valid",  m, 64'(out_valid_m[m]),64'(exp_ov));
        chk("frame_done", m, 64'(fd_m[m]),       64'(mdl_fd[m]));
        if (fd_m[m] === 1'b1) dut_fd_pulses[m]++;
    endtask

    task automatic push(input int m, input logic [WIDTH-1:0] v);
        if (m == 0) sbq0.push_back(v);
        else        sbq1.push_back(v);
    endtask

    // One clock cycle on instance m: check state, drive, advance model, clock.
    task automatic cycle(input int m, input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        bit exp_ir, exp_ov, wr, rd;
        int nc;
        status(m);
        expect_flags(m, exp_ir, exp_ov);
        in_valid_d[m]  = iv;
        in_data_d[m]   = d;
        out_ready_d[m] = ordy;
        flush_d[m]     = fl;
        wr = iv && exp_ir && !fl;
        rd = ordy && exp_ov && !fl;
        if (fl) begin
            if (m == 0) sbq0.delete();
            else        sbq1.delete();
            mdl_cnt[m]   = 0;
            mdl_drain[m] = 1'b0;
            mdl_fd[m]    = 1'b0;
        end else begin
            if (wr) begin
                for (int k = 0; k < LANES; k++) push(m, d[k*WIDTH +: WIDTH]);
            end
            nc = mdl_cnt[m] + (wr ? LANES : 0) - (rd ? 1 : 0);
            mdl_fd[m] = (m == 1) && mdl_drain[m] && rd && (nc == 0);
            if (m == 1) begin
                if (!mdl_drain[m] && wr && nc == DEPTH) mdl_drain[m] = 1'b1;
                else if (mdl_drain[m] && rd && nc == 0) mdl_drain[m] = 1'b0;
            end
            mdl_cnt[m] = nc;
        end
        @(posedge clk);
        #1;
        in_valid_d[m]  = 1'b0;
        out_ready_d[m] = 1'b0;
        flush_d[m]     = 1'b0;
    endtask

    function automatic logic [DW-1:0] next_beat();
        logic [DW-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*WIDTH +: WIDTH] = WIDTH'(seq + k);
        seq += LANES;
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*WIDTH +: WIDTH] = $urandom;
        return d;
    endfunction

    task automatic drain_stream();
        for (int i = 0; i < DEPTH + 2 && mdl_cnt[0] > 0; i++) cycle(0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: every completed read pops the oldest expected sample.
    logic [WIDTH-1:0] e0, e1;
    always @(negedge clk) begin
        if (rst === 1'b0 && flush_d[0] === 1'b0 && out_valid_m[0] === 1'b1 && out_ready_d[0] === 1'b1) begin
            if (sbq0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL out_data dut0: read %0h with nothing expected", out_data_m[0]);
            end else begin
                e0 = sbq0.pop_front();
                chk("out_data", 0, 64'(out_data_m[0]), 64'(e0));
            end
        end
        if (rst === 1'b0 && flush_d[1] === 1'b0 && out_valid_m[1] === 1'b1 && out_ready_d[1] === 1'b1) begin
            if (sbq1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL out_data dut1: read %0h with nothing expected", out_data_m[1]);
            end else begin
                e1 = sbq1.pop_front();
                chk("out_data", 1, 64'(out_data_m[1]), 64'(e1));
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            flush_d[m] = 1'b0; in_valid_d[m] = 1'b1; out_ready_d[m] = 1'b0;
            in_data_d[m] = '1;
            mdl_cnt[m] = 0; mdl_drain[m] = 1'b0; mdl_fd[m] = 1'b0; dut_fd_pulses[m] = 0;
        end
        seq = 0;

        // Reset with in_valid asserted for two cycles
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                chk("rst_count",    m, 64'(count_m[m]),    64'd0);
                chk("rst_empty",    m, 64'(empty_m[m]),    64'd1);
                chk("rst_in_ready", m, 64'(in_ready_m[m]), 64'd0);
            end
        end
        rst = 1'b0;
        in_valid_d[0] = 1'b0; in_valid_d[1] = 1'b0;
        #1;
        status(0); status(1);
        cycle(0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1, 1'b0, '0, 1'b1, 1'b0);

        // STREAM fill to full, refused extra beat, ordered drain, read on empty
        for (int k = 0; k < DEPTH / LANES; k++) cycle(0, 1'b1, next_beat(), 1'b0, 1'b0);
        cycle(0, 1'b1, rand_beat(), 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) cycle(0, 1'b0, '0, 1'b1, 1'b0);
        cycle(0, 1'b0, '0, 1'b1, 1'b0);

        // STREAM concurrency: 10 stored, write+read -> 11
        for (int k = 0; k < 5; k++) cycle(0, 1'b1, next_beat(), 1'b0, 1'b0);
        cycle(0, 1'b1, next_beat(), 1'b1, 1'b0);
        status(0);
        drain_stream();
        // 63 stored: no room for a beat even while reading
        for (int k = 0; k < DEPTH / LANES; k++) cycle(0, 1'b1, next_beat(), 1'b0, 1'b0);
        cycle(0, 1'b0, '0, 1'b1, 1'b0);
        cycle(0, 1'b1, next_beat(), 1'b1, 1'b0);
        drain_stream();

        // STREAM wrap: contiguous 0..199
        seq = 0;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 10; k++) cycle(0, 1'b1, next_beat(), 1'b0, 1'b0);
            for (int k = 0; k < 20; k++) cycle(0, 1'b0, '0, 1'b1, 1'b0);
        end
        status(0);

        // STREAM random traffic with occasional flush
        for (int i = 0; i < 600; i++)
            cycle(0, 1'($urandom_range(0, 1)), rand_beat(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 63) == 0));
        drain_stream();
        chk("stream_leftover", 0, 64'(sbq0.size()), 64'(mdl_cnt[0]));

        // FRAME: fill (reads ignored), drain (writes ignored), one frame_done pulse
        seq = 1000;
        dut_fd_pulses[1] = 0;
        for (int k = 0; k < DEPTH / LANES; k++) cycle(1, 1'b1, next_beat(), 1'b1, 1'b0);
        for (int k = 0; k < DEPTH; k++) cycle(1, 1'b1, rand_beat(), 1'b1, 1'b0);
        cycle(1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1, 1'b0, '0, 1'b0, 1'b0);
        chk("frame_done_pulses", 1, 64'(dut_fd_pulses[1]), 64'd1);

        // FRAME flush at count 40 during DRAIN, then a clean frame
        dut_fd_pulses[1] = 0;
        for (int k = 0; k < DEPTH / LANES; k++) cycle(1, 1'b1, next_beat(), 1'b0, 1'b0);
        for (int k = 0; k < 24; k++) cycle(1, 1'b0, '0, 1'b1, 1'b0);
        status(1);
        cycle(1, 1'b1, rand_beat(), 1'b1, 1'b1);
        cycle(1, 1'b0, '0, 1'b0, 1'b0);
        chk("flush_no_frame_done", 1, 64'(dut_fd_pulses[1]), 64'd0);
        for (int k = 0; k < DEPTH / LANES; k++) cycle(1, 1'b1, next_beat(), 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) cycle(1, 1'b0, '0, 1'b1, 1'b0);
        cycle(1, 1'b0, '0, 1'b0, 1'b0);
        chk("frame_done_after_flush", 1, 64'(dut_fd_pulses[1]), 64'd1);

        // FRAME random traffic with rare flush
        for (int i = 0; i < 900; i++)
            cycle(1, 1'($urandom_range(0, 3) != 0), rand_beat(), 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 199) == 0));
        status(1);
        chk("frame_leftover", 1, 64'(sbq1.size()), 64'(mdl_cnt[1]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
